// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-banked dual-port memory.
//   access_size_t : log2 of the access width in bytes (byte/half/word/dword)
//   mem_state_t   : controller state, zero-clear sequence then normal operation
//   access_fault  : range/size check for an access of 2**size_log2 bytes
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } access_size_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_t;

  // True when the access is wider than a bank word or runs past the last byte.
  // Carried out in 33 bits so an access ending at the top never wraps to look legal.
  function automatic logic access_fault(input logic [31:0] addr,
                                        input int unsigned size_log2,
                                        input int unsigned max_size_log2,
                                        input int unsigned total_bytes);
    logic [32:0] end_addr;
    end_addr = {1'b0, addr} + (33'd1 << size_log2);
    return (size_log2 > max_size_log2) || (end_addr > {1'b0, total_bytes});
  endfunction

endpackage

// File: rtl/byte_bank_rf.sv
// One byte-wide bank of the memory: DEPTH x 8 bits.
//   clk_i      : clock
//   a_en_i     : port A enable (read, plus write when a_we_i)
//   a_we_i     : port A write enable
//   a_addr_i   : port A row
//   a_wdata_i  : port A write byte
//   a_rdata_o  : port A registered read byte (read-first)
//   b_en_i     : port B read enable
//   b_addr_i   : port B row
//   b_rdata_o  : port B registered read byte (sees the value before a same-edge A write)
module byte_bank_rf #(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          a_en_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [7:0]    a_wdata_i,
  output logic [7:0]    a_rdata_o,
  input  logic          b_en_i,
  input  logic [AW-1:0] b_addr_i,
  output logic [7:0]    b_rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] a_rdata_q;
  logic [7:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    if (a_en_i) begin
      if (a_we_i) begin
        mem_q[a_addr_i] <= a_wdata_i;
      end
      a_rdata_q <= mem_q[a_addr_i];
    end
    if (b_en_i) begin
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/banked_dual_port_memory.sv
// Byte-banked dual-port memory.
//   Port A (data)       : byte/half/word(/dword) loads and stores, misaligned allowed,
//                         optional sign extension, range/size faults.
//   Port B (instruction): read-only full-word fetches, range faults.
//   Optional zero-clear of all banks after reset (CLEAR_ON_RESET).
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   init_done                       : clear sequence finished (or skipped)
//   a_req/a_ready/a_we/a_size/a_signed/a_addr/a_wdata : data request
//   a_rvalid/a_rdata/a_fault        : data response, two cycles after accept
//   b_req/b_ready/b_addr            : fetch request
//   b_rvalid/b_rdata/b_fault        : fetch response, two cycles after accept
module banked_dual_port_memory
  import mem_pkg::*;
#(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned BANK_DEPTH     = 4096,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned WORD_W        = 8 * NUM_BANKS,
  localparam int unsigned TOTAL_BYTES   = NUM_BANKS * BANK_DEPTH,
  localparam int unsigned ADDR_W        = $clog2(TOTAL_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              a_req,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_signed,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WORD_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [WORD_W-1:0] a_rdata,
  output logic              a_fault,
  input  logic              b_req,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_rvalid,
  output logic [WORD_W-1:0] b_rdata,
  output logic              b_fault
);

  localparam int unsigned LB = $clog2(NUM_BANKS);
  localparam int unsigned RW = $clog2(BANK_DEPTH);

  // Controller
  mem_state_t    state_q, state_d;
  logic [RW-1:0] init_cnt_q, init_cnt_d;
  logic          init_done_q;

  // Request decode
  logic          a_acc, b_acc;
  logic          a_flt, b_flt;
  logic [LB-1:0] a_sb, b_sb;
  logic [RW-1:0] a_row, b_row;
  logic [NUM_BANKS-1:0][LB-1:0] a_k;

  // Bank interface
  logic [NUM_BANKS-1:0]         bank_a_en, bank_a_we, bank_b_en;
  logic [NUM_BANKS-1:0][RW-1:0] bank_a_addr, bank_b_addr;
  logic [NUM_BANKS-1:0][7:0]    bank_a_wdata, bank_a_rd, bank_b_rd;

  // Port A pipeline
  logic          a_s1_vld_q, a_s1_we_q, a_s1_flt_q, a_s1_sgn_q;
  logic [LB-1:0] a_s1_sb_q;
  access_size_t  a_s1_size_q;
  logic          a_s2_vld_q, a_s2_we_q, a_s2_flt_q, a_s2_sgn_q;
  access_size_t  a_s2_size_q;
  logic [WORD_W-1:0] a_rot, a_s2_rot_q, a_fmt;
  logic              a_rvalid_q, a_fault_q;
  logic [WORD_W-1:0] a_rdata_q;

  // Port B pipeline
  logic          b_s1_vld_q, b_s1_flt_q;
  logic [LB-1:0] b_s1_sb_q;
  logic          b_s2_vld_q, b_s2_flt_q;
  logic [WORD_W-1:0] b_rot, b_s2_rot_q;
  logic              b_rvalid_q, b_fault_q;
  logic [WORD_W-1:0] b_rdata_q;

  // ---------------------------------------------------------------- controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_q == ST_RUN);
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + RW'(1);
        if (init_cnt_q == RW'(BANK_DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- decode
  assign a_acc = a_req && init_done_q;
  assign b_acc = b_req && init_done_q;
  assign a_sb  = a_addr[LB-1:0];
  assign a_row = a_addr[ADDR_W-1:LB];
  assign b_sb  = b_addr[LB-1:0];
  assign b_row = b_addr[ADDR_W-1:LB];
  assign a_flt = access_fault(32'(a_addr), 32'(a_size), LB, TOTAL_BYTES);
  assign b_flt = access_fault(32'(b_addr), LB, LB, TOTAL_BYTES);

  // Byte position within the access that bank i holds.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      a_k[i] = LB'(i) - a_sb;
    end
  end

  // Banks below the start bank hold the bytes that spill into the next row.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (state_q == ST_INIT) begin
        bank_a_en[i]    = 1'b1;
        bank_a_we[i]    = 1'b1;
        bank_a_addr[i]  = init_cnt_q;
        bank_a_wdata[i] = '0;
      end else begin
        bank_a_en[i]    = a_acc;
        bank_a_we[i]    = a_acc && a_we && !a_flt && (32'(a_k[i]) < (32'd1 << a_size));
        bank_a_addr[i]  = (LB'(i) < a_sb) ? a_row + RW'(1) : a_row;
        bank_a_wdata[i] = a_wdata[{a_k[i], 3'b000} +: 8];
      end
      bank_b_en[i]   = b_acc;
      bank_b_addr[i] = (LB'(i) < b_sb) ? b_row + RW'(1) : b_row;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    byte_bank_rf #(
      .DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk_i     (clk),
      .a_en_i    (bank_a_en[g]),
      .a_we_i    (bank_a_we[g]),
      .a_addr_i  (bank_a_addr[g]),
      .a_wdata_i (bank_a_wdata[g]),
      .a_rdata_o (bank_a_rd[g]),
      .b_en_i    (bank_b_en[g]),
      .b_addr_i  (bank_b_addr[g]),
      .b_rdata_o (bank_b_rd[g])
    );
  end

  // ---------------------------------------------------------------- read datapath
  // Rotate bank outputs so access byte 0 lands in the LSB.
  always_comb begin
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      a_rot[8*k +: 8] = bank_a_rd[a_s1_sb_q + LB'(k)];
      b_rot[8*k +: 8] = bank_b_rd[b_s1_sb_q + LB'(k)];
    end
  end

  // Keep the low 2**size bytes; fill the rest with zero or the top kept bit.
  always_comb begin
    logic sign;
    sign  = 1'b0;
    a_fmt = '0;
    for (int unsigned j = 0; j < NUM_BANKS; j++) begin
      if (j < (32'd1 << 32'(a_s2_size_q))) begin
        a_fmt[8*j +: 8] = a_s2_rot_q[8*j +: 8];
        sign            = a_s2_rot_q[8*j + 7];
      end
    end
    for (int unsigned j = 0; j < NUM_BANKS; j++) begin
      if (j >= (32'd1 << 32'(a_s2_size_q))) begin
        a_fmt[8*j +: 8] = {8{a_s2_sgn_q && sign}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_vld_q  <= 1'b0;
      a_s1_we_q   <= 1'b0;
      a_s1_flt_q  <= 1'b0;
      a_s1_sgn_q  <= 1'b0;
      a_s1_sb_q   <= '0;
      a_s1_size_q <= SIZE_B;
      a_s2_vld_q  <= 1'b0;
      a_s2_we_q   <= 1'b0;
      a_s2_flt_q  <= 1'b0;
      a_s2_sgn_q  <= 1'b0;
      a_s2_size_q <= SIZE_B;
      a_s2_rot_q  <= '0;
      a_rvalid_q  <= 1'b0;
      a_fault_q   <= 1'b0;
      a_rdata_q   <= '0;
      b_s1_vld_q  <= 1'b0;
      b_s1_flt_q  <= 1'b0;
      b_s1_sb_q   <= '0;
      b_s2_vld_q  <= 1'b0;
      b_s2_flt_q  <= 1'b0;
      b_s2_rot_q  <= '0;
      b_rvalid_q  <= 1'b0;
      b_fault_q   <= 1'b0;
      b_rdata_q   <= '0;
    end else begin
      a_s1_vld_q  <= a_acc;
      a_s1_we_q   <= a_we;
      a_s1_flt_q  <= a_flt;
      a_s1_sgn_q  <= a_signed;
      a_s1_sb_q   <= a_sb;
      a_s1_size_q <= access_size_t'(a_size);
      a_s2_vld_q  <= a_s1_vld_q;
      a_s2_we_q   <= a_s1_we_q;
      a_s2_flt_q  <= a_s1_flt_q;
      a_s2_sgn_q  <= a_s1_sgn_q;
      a_s2_size_q <= a_s1_size_q;
      a_s2_rot_q  <= a_rot;
      a_rvalid_q  <= a_s2_vld_q;
      a_fault_q   <= a_s2_vld_q && a_s2_flt_q;
      a_rdata_q   <= (a_s2_vld_q && !a_s2_we_q && !a_s2_flt_q) ? a_fmt : '0;
      b_s1_vld_q  <= b_acc;
      b_s1_flt_q  <= b_flt;
      b_s1_sb_q   <= b_sb;
      b_s2_vld_q  <= b_s1_vld_q;
      b_s2_flt_q  <= b_s1_flt_q;
      b_s2_rot_q  <= b_rot;
      b_rvalid_q  <= b_s2_vld_q;
      b_fault_q   <= b_s2_vld_q && b_s2_flt_q;
      b_rdata_q   <= (b_s2_vld_q && !b_s2_flt_q) ? b_s2_rot_q : '0;
    end
  end

  assign init_done = init_done_q;
  assign a_ready   = init_done_q;
  assign b_ready   = init_done_q;
  assign a_rvalid  = a_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign a_fault   = a_fault_q;
  assign b_rvalid  = b_rvalid_q;
  assign b_rdata   = b_rdata_q;
  assign b_fault   = b_fault_q;

endmodule

// File: tb/tb_banked_dual_port_memory.sv
// Directed bench for banked_dual_port_memory (4 banks x 16 bytes, 64 bytes total).
// A second instance with the clear sequence disabled shares clock and reset.
module tb_banked_dual_port_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done, a_ready, b_ready;
  logic        a_req = 1'b0, a_we = 1'b0, a_signed = 1'b0;
  logic [1:0]  a_size = 2'd0;
  logic [5:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        a_rvalid, a_fault, b_req = 1'b0, b_rvalid, b_fault;
  logic [31:0] a_rdata, b_rdata;

  logic        z_init_done, z_a_ready, z_a_rvalid, z_a_fault, z_b_ready, z_b_rvalid, z_b_fault;
  logic [31:0] z_a_rdata, z_b_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  banked_dual_port_memory #(
    .NUM_BANKS      (4),
    .BANK_DEPTH     (16),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .a_req     (a_req),
    .a_ready   (a_ready),
    .a_we      (a_we),
    .a_size    (a_size),
    .a_signed  (a_signed),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .a_fault   (a_fault),
    .b_req     (b_req),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .b_fault   (b_fault)
  );

  banked_dual_port_memory #(
    .NUM_BANKS      (4),
    .BANK_DEPTH     (16),
    .CLEAR_ON_RESET (1'b0)
  ) dut_noclr (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (z_init_done),
    .a_req     (1'b0),
    .a_ready   (z_a_ready),
    .a_we      (1'b0),
    .a_size    (2'd0),
    .a_signed  (1'b0),
    .a_addr    (6'd0),
    .a_wdata   (32'd0),
    .a_rvalid  (z_a_rvalid),
    .a_rdata   (z_a_rdata),
    .a_fault   (z_a_fault),
    .b_req     (1'b0),
    .b_ready   (z_b_ready),
    .b_addr    (6'd0),
    .b_rvalid  (z_b_rvalid),
    .b_rdata   (z_b_rdata),
    .b_fault   (z_b_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that releases nothing; reset already deasserted.
  task automatic wait_init(input string tag);
    step();
    chk({tag, "_noclr_done_e1"}, 32'(z_init_done), 32'd1);
    chk({tag, "_ready_e1"}, 32'(a_ready), 32'd0);
    chk({tag, "_rvalid_e1"}, 32'(a_rvalid), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      step();
      chk({tag, "_ready_low"}, 32'(a_ready), 32'd0);
    end
    step();
    chk({tag, "_init_done_e17"}, 32'(init_done), 32'd1);
    chk({tag, "_a_ready_e17"}, 32'(a_ready), 32'd1);
    chk({tag, "_b_ready_e17"}, 32'(b_ready), 32'd1);
  endtask

  task automatic do_a(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [5:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_d, input logic exp_f, input string tag);
    a_req = 1'b1; a_we = we; a_size = size; a_signed = sgn; a_addr = addr; a_wdata = wdata;
    step();
    a_req = 1'b0; a_we = 1'b0;
    step();
    chk({tag, "_rvalid_early"}, 32'(a_rvalid), 32'd0);
    step();
    chk({tag, "_rvalid"}, 32'(a_rvalid), 32'd1);
    chk({tag, "_rdata"}, a_rdata, exp_d);
    chk({tag, "_fault"}, 32'(a_fault), 32'(exp_f));
  endtask

  task automatic do_b(input logic [5:0] addr, input logic [31:0] exp_d, input logic exp_f,
                      input string tag);
    b_req = 1'b1; b_addr = addr;
    step();
    b_req = 1'b0;
    step();
    chk({tag, "_rvalid_early"}, 32'(b_rvalid), 32'd0);
    step();
    chk({tag, "_rvalid"}, 32'(b_rvalid), 32'd1);
    chk({tag, "_rdata"}, b_rdata, exp_d);
    chk({tag, "_fault"}, 32'(b_fault), 32'(exp_f));
  endtask

  initial begin
    // 1. reset values, clear sequence, first fetch
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_noclr_done", 32'(z_init_done), 32'd0);
    rst_n = 1'b1;
    wait_init("init1");
    do_b(6'h00, 32'h0000_0000, 1'b0, "fetch00");

    // 2. misaligned word store and assorted loads/fetch
    do_a(1'b1, 2'd2, 1'b0, 6'h05, 32'hDDCC_BBAA, 32'h0, 1'b0, "st_w05");
    do_a(1'b0, 2'd2, 1'b0, 6'h05, 32'h0, 32'hDDCC_BBAA, 1'b0, "ld_w05");
    do_a(1'b0, 2'd0, 1'b0, 6'h08, 32'h0, 32'h0000_00DD, 1'b0, "ld_b08");
    do_a(1'b0, 2'd0, 1'b0, 6'h04, 32'h0, 32'h0000_0000, 1'b0, "ld_b04");
    do_b(6'h04, 32'hCCBB_AA00, 1'b0, "fetch04");

    // 3. sign extension
    do_a(1'b1, 2'd0, 1'b0, 6'h20, 32'hFFFF_FF80, 32'h0, 1'b0, "st_b20");
    do_a(1'b0, 2'd0, 1'b1, 6'h20, 32'h0, 32'hFFFF_FF80, 1'b0, "ld_sb20");
    do_a(1'b0, 2'd0, 1'b0, 6'h20, 32'h0, 32'h0000_0080, 1'b0, "ld_ub20");
    do_a(1'b1, 2'd1, 1'b0, 6'h21, 32'hAAAA_8001, 32'h0, 1'b0, "st_h21");
    do_a(1'b0, 2'd1, 1'b1, 6'h21, 32'h0, 32'hFFFF_8001, 1'b0, "ld_sh21");
    do_a(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, 32'h0080_0180, 1'b0, "ld_w20");

    // 4. faults at the top of memory and oversize access
    do_a(1'b1, 2'd2, 1'b0, 6'h3E, 32'h1234_5678, 32'h0, 1'b1, "st_w3e_flt");
    do_a(1'b0, 2'd1, 1'b0, 6'h3E, 32'h0, 32'h0000_0000, 1'b0, "ld_h3e");
    do_a(1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 32'h0000_0000, 1'b0, "ld_w3c");
    do_a(1'b0, 2'd1, 1'b1, 6'h3F, 32'h0, 32'h0000_0000, 1'b1, "ld_h3f_flt");
    do_a(1'b0, 2'd3, 1'b0, 6'h00, 32'h0, 32'h0000_0000, 1'b1, "ld_d00_flt");
    do_b(6'h3D, 32'h0000_0000, 1'b1, "fetch3d_flt");
    do_b(6'h3C, 32'h0000_0000, 1'b0, "fetch3c");

    // 5. same-edge store and fetch: fetch is read-first
    a_req = 1'b1; a_we = 1'b1; a_size = 2'd2; a_signed = 1'b0; a_addr = 6'h10;
    a_wdata = 32'h1122_3344; b_req = 1'b1; b_addr = 6'h10;
    step();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
    step();
    step();
    chk("coll_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("coll_b_rvalid", 32'(b_rvalid), 32'd1);
    chk("coll_b_old", b_rdata, 32'h0000_0000);
    do_b(6'h10, 32'h1122_3344, 1'b0, "fetch10_new");

    // back-to-back loads, one per cycle
    a_req = 1'b1; a_we = 1'b0; a_signed = 1'b0; a_size = 2'd0; a_addr = 6'h10;
    step();
    a_addr = 6'h11;
    step();
    chk("b2b_early", 32'(a_rvalid), 32'd0);
    a_size = 2'd1; a_addr = 6'h12;
    step();
    chk("b2b0_rvalid", 32'(a_rvalid), 32'd1);
    chk("b2b0_rdata", a_rdata, 32'h0000_0044);
    a_size = 2'd2; a_addr = 6'h05;
    step();
    a_req = 1'b0;
    chk("b2b1_rvalid", 32'(a_rvalid), 32'd1);
    chk("b2b1_rdata", a_rdata, 32'h0000_0033);
    step();
    chk("b2b2_rvalid", 32'(a_rvalid), 32'd1);
    chk("b2b2_rdata", a_rdata, 32'h0000_1122);
    step();
    chk("b2b3_rvalid", 32'(a_rvalid), 32'd1);
    chk("b2b3_rdata", a_rdata, 32'hDDCC_BBAA);
    step();
    chk("b2b_after", 32'(a_rvalid), 32'd0);

    // 6. reset with loads in flight
    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_addr = 6'h05;
    step();
    a_addr = 6'h10;
    step();
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst2_init_done", 32'(init_done), 32'd0);
    chk("rst2_noclr_done", 32'(z_init_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst2_no_rvalid", 32'(a_rvalid), 32'd0);
    end
    rst_n = 1'b1;
    wait_init("init2");
    do_a(1'b0, 2'd2, 1'b0, 6'h05, 32'h0, 32'h0000_0000, 1'b0, "ld_w05_cleared");
    do_b(6'h10, 32'h0000_0000, 1'b0, "fetch10_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
